intr_ctrl: RTL and testbench

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_intr_ctrl.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Interrupt controller: per-source edge/level capture, fixed-priority arbitration
// (lowest index wins), and a three-state present/ack/service handshake with a CPU.
// Also holds a small register file: global enable, mask, vector base, pending.
module intr_ctrl #(
    parameter int unsigned          NUM_SRC         = 8,
    parameter logic [NUM_SRC-1:0]   EDGE_MASK       = '0,
    parameter int unsigned          VEC_STRIDE_LOG2 = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_req,
    input  logic               wr_en,
    input  logic [1:0]         addr,
    input  logic [31:0]        wr_data,
    output logic [31:0]        rd_data,
    output logic               irq,
    output logic [3:0]         irq_id,
    output logic [31:0]        irq_vec,
    input  logic               ack,
    input  logic               eoi
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StPresent = 2'd1;
    localparam logic [1:0] StService = 2'd2;

    localparam logic [1:0] AddrGlobalEn = 2'd0;
    localparam logic [1:0] AddrMask     = 2'd1;
    localparam logic [1:0] AddrVecBase  = 2'd2;
    localparam logic [1:0] AddrPending  = 2'd3;

    // Configuration registers
    logic               global_en_q, global_en_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [31:0]        vec_base_q, vec_base_d;

    // Capture state
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] src_prev_q;

    // Handshake state
    logic [1:0]         state_q, state_d;
    logic [3:0]         irq_id_q, irq_id_d;

    // Derived signals
    logic [NUM_SRC-1:0] edge_det;
    logic [NUM_SRC-1:0] w1c_bits;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] edge_next;
    logic [NUM_SRC-1:0] eligible;
    logic               win_any;
    logic [3:0]         win_id;
    logic               cur_elig;
    logic               ack_take;
    logic [31:0]        vec_sum;

    // Register file next-state: writes land on the edge where wr_en is high
    always_comb begin
        global_en_d = global_en_q;
        mask_d      = mask_q;
        vec_base_d  = vec_base_q;
        if (wr_en) begin
            case (addr)
                AddrGlobalEn: global_en_d = wr_data[0];
                AddrMask:     mask_d      = wr_data[NUM_SRC-1:0];
                AddrVecBase:  vec_base_d  = wr_data;
                default:      ;
            endcase
        end
    end

    // Pending next-state: edge sources latch rises (set beats clear), level sources track src_req
    always_comb begin
        edge_det = src_req & ~src_prev_q;
        w1c_bits = (wr_en && (addr == AddrPending)) ? wr_data[NUM_SRC-1:0] : '0;
        ack_clr  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ack_clr[i] = ack_take && (irq_id_q == 4'(i));
        end
        edge_next = edge_det | (pending_q & ~(w1c_bits | ack_clr));
        pending_d = (EDGE_MASK & edge_next) | (~EDGE_MASK & src_req);
    end

    // Arbitration: lowest eligible index wins; also track whether the held id is still eligible
    always_comb begin
        eligible = pending_q & mask_q & {NUM_SRC{global_en_q}};
        win_any  = |eligible;
        win_id   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id = 4'(i);
            end
        end
        cur_elig = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if ((irq_id_q == 4'(i)) && eligible[i]) begin
                cur_elig = 1'b1;
            end
        end
    end

    // Handshake FSM: IDLE -> PRESENT on any eligible source, ack -> SERVICE, eoi -> IDLE
    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        ack_take = 1'b0;
        case (state_q)
            StIdle: begin
                if (win_any) begin
                    state_d  = StPresent;
                    irq_id_d = win_id;
                end
            end
            StPresent: begin
                // Losing eligibility withdraws the request even if ack arrives the same cycle
                if (!cur_elig) begin
                    state_d = StIdle;
                end else if (ack) begin
                    state_d  = StService;
                    ack_take = 1'b1;
                end
            end
            StService: begin
                if (eoi) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Configuration register state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            global_en_q <= 1'b0;
            mask_q      <= '0;
            vec_base_q  <= '0;
        end else begin
            global_en_q <= global_en_d;
            mask_q      <= mask_d;
            vec_base_q  <= vec_base_d;
        end
    end

    // Capture state; history clears in reset so a level held through release reads as a new edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q  <= '0;
            src_prev_q <= '0;
        end else begin
            pending_q  <= pending_d;
            src_prev_q <= src_req;
        end
    end

    // Handshake state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            irq_id_q <= '0;
        end else begin
            state_q  <= state_d;
            irq_id_q <= irq_id_d;
        end
    end

    // Outputs: vector arithmetic wraps modulo 2^32; read data and vector forced to 0 in reset
    always_comb begin
        irq     = (state_q == StPresent);
        irq_id  = irq_id_q;
        vec_sum = vec_base_q + (32'(irq_id_q) << VEC_STRIDE_LOG2);
        irq_vec = reset ? vec_sum : 32'd0;
        rd_data = 32'd0;
        if (reset) begin
            case (addr)
                AddrGlobalEn: rd_data = {31'd0, global_en_q};
                AddrMask:     rd_data = 32'(mask_q);
                AddrVecBase:  rd_data = vec_base_q;
                AddrPending:  rd_data = 32'(pending_q);
                default:      rd_data = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: sources 0..6 edge mode, source 7 level mode.
module tb_intr_ctrl;

    logic        clk;
    logic        reset;
    logic [7:0]  src_req;
    logic        wr_en;
    logic [1:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        irq;
    logic [3:0]  irq_id;
    logic [31:0] irq_vec;
    logic        ack;
    logic        eoi;

    int n_cmp = 0;
    int n_err = 0;

    // Expected presentations: {irq_id, irq_vec}
    logic [35:0] exp_q[$];

    intr_ctrl #(
        .NUM_SRC        (8),
        .EDGE_MASK      (8'h7F),
        .VEC_STRIDE_LOG2(2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .src_req(src_req),
        .wr_en  (wr_en),
        .addr   (addr),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .irq    (irq),
        .irq_id (irq_id),
        .irq_vec(irq_vec),
        .ack    (ack),
        .eoi    (eoi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, wanted finish)");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
        wr_en = 1'b1; addr = a; wr_data = d;
        step();
        wr_en = 1'b0; wr_data = '0;
    endtask

    task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rd_data;
    endtask

    task automatic do_ack();
        ack = 1'b1; step(); ack = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1; step(); eoi = 1'b0;
    endtask

    task automatic wait_irq(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (irq === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq got=%b want=0", irq); end
        n_cmp++; if (irq_id !== 4'd0) begin n_err++; $display("FAIL rst_id got=%0d want=0", irq_id); end
        n_cmp++; if (irq_vec !== 32'd0) begin n_err++; $display("FAIL rst_vec got=%h want=0", irq_vec); end
        for (int a = 0; a < 4; a++) begin
            reg_rd(2'(a), d);
            n_cmp++;
            if (d !== 32'd0) begin n_err++; $display("FAIL rst_rd%0d got=%h want=0", a, d); end
        end
        reset = 1'b1;
        step();
        for (int a = 0; a < 4; a++) begin
            reg_rd(2'(a), d);
            n_cmp++;
            if (d !== 32'd0) begin n_err++; $display("FAIL post_rst_rd%0d got=%h want=0", a, d); end
        end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic [35:0] e;
        reg_wr(2'd1, 32'h0000_01FF);
        reg_wr(2'd0, 32'hFFFF_FFFF);
        reg_wr(2'd2, 32'h0000_0100);
        reg_rd(2'd1, d);
        n_cmp++; if (d !== 32'h0000_00FF) begin n_err++; $display("FAIL rd_mask got=%h want=000000ff", d); end
        reg_rd(2'd0, d);
        n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL rd_gen got=%h want=1", d); end
        reg_rd(2'd2, d);
        n_cmp++; if (d !== 32'h100) begin n_err++; $display("FAIL rd_vbase got=%h want=100", d); end
        src_req[3] = 1'b1;
        exp_q.push_back({4'd3, 32'h10C});
        step();
        src_req[3] = 1'b0;
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL lat1 got=%b want=0", irq); end
        step();
        n_cmp++;
        if (irq !== 1'b1) begin
            n_err++; $display("FAIL lat2 got=%b want=1", irq);
        end else if (exp_q.size() == 0) begin
            n_err++; $display("FAIL sb_empty got=present want=none");
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({irq_id, irq_vec} !== e) begin
                n_err++; $display("FAIL basic_present got=%0d/%h want=%0d/%h", irq_id, irq_vec, e[35:32], e[31:0]);
            end
        end
        do_ack();
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL ack_drop got=%b want=0", irq); end
        reg_rd(2'd3, d);
        n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL ack_clr got=%h want=0", d); end
        do_eoi();
    endtask

    task automatic test_priority();
        bit seen;
        logic [35:0] e;
        src_req[5] = 1'b1; src_req[2] = 1'b1;
        exp_q.push_back({4'd2, 32'h108});
        exp_q.push_back({4'd5, 32'h114});
        step();
        src_req = '0;
        for (int k = 0; k < 2; k++) begin
            wait_irq(8, seen);
            n_cmp++;
            if (!seen) begin
                n_err++; $display("FAIL prio_timeout%0d got=no_irq want=irq", k);
            end else if (exp_q.size() == 0) begin
                n_err++; $display("FAIL sb_empty got=present want=none");
            end else begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({irq_id, irq_vec} !== e) begin
                    n_err++; $display("FAIL prio%0d got=%0d/%h want=%0d/%h", k, irq_id, irq_vec, e[35:32], e[31:0]);
                end
            end
            if (k == 1) begin
                // Higher-priority source arrives while 5 is presented: id must hold
                src_req[1] = 1'b1;
                exp_q.push_back({4'd1, 32'h104});
                step();
                src_req[1] = 1'b0;
                step(); step();
                n_cmp++;
                if (irq !== 1'b1 || irq_id !== 4'd5) begin
                    n_err++; $display("FAIL hold_id got=%b/%0d want=1/5", irq, irq_id);
                end
            end
            do_ack();
            do_eoi();
        end
        wait_irq(8, seen);
        n_cmp++;
        if (!seen) begin
            n_err++; $display("FAIL prio_timeout2 got=no_irq want=irq");
        end else if (exp_q.size() == 0) begin
            n_err++; $display("FAIL sb_empty got=present want=none");
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({irq_id, irq_vec} !== e) begin
                n_err++; $display("FAIL prio2 got=%0d/%h want=%0d/%h", irq_id, irq_vec, e[35:32], e[31:0]);
            end
        end
        do_ack();
        do_eoi();
    endtask

    task automatic test_mask_drop();
        bit seen;
        logic [35:0] e;
        logic [31:0] d;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                src_req[4] = 1'b1;
                exp_q.push_back({4'd4, 32'h110});
                step();
                src_req[4] = 1'b0;
            end else begin
                exp_q.push_back({4'd4, 32'h110});
                reg_wr(2'd1, 32'hFF);
            end
            wait_irq(8, seen);
            n_cmp++;
            if (!seen) begin
                n_err++; $display("FAIL mask_timeout%0d got=no_irq want=irq", k);
            end else if (exp_q.size() == 0) begin
                n_err++; $display("FAIL sb_empty got=present want=none");
            end else begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({irq_id, irq_vec} !== e) begin
                    n_err++; $display("FAIL mask_present%0d got=%0d/%h want=%0d/%h", k, irq_id, irq_vec, e[35:32], e[31:0]);
                end
            end
            if (k == 0) begin
                reg_wr(2'd1, 32'hEF);
                step();
                n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mask_drop got=%b want=0", irq); end
                reg_rd(2'd3, d);
                n_cmp++; if (d !== 32'h10) begin n_err++; $display("FAIL mask_pend got=%h want=10", d); end
                step();
                n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mask_idle got=%b want=0", irq); end
            end
        end
        do_ack();
        do_eoi();
    endtask

    task automatic test_w1c_level();
        bit seen;
        logic [35:0] e;
        logic [31:0] d;
        reg_wr(2'd0, 32'h0);
        src_req[6] = 1'b1; step(); src_req[6] = 1'b0; step();
        reg_rd(2'd3, d);
        n_cmp++; if (d !== 32'h40) begin n_err++; $display("FAIL edge_pend got=%h want=40", d); end
        // W1C and a new rise on the same bit in one cycle
        src_req[6] = 1'b1;
        reg_wr(2'd3, 32'h40);
        reg_rd(2'd3, d);
        n_cmp++; if (d !== 32'h40) begin n_err++; $display("FAIL set_wins got=%h want=40", d); end
        reg_wr(2'd3, 32'h40);
        reg_rd(2'd3, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL w1c got=%h want=0", d); end
        src_req[6] = 1'b0;
        src_req[7] = 1'b1; step();
        reg_rd(2'd3, d);
        n_cmp++; if (d !== 32'h80) begin n_err++; $display("FAIL lvl_pend got=%h want=80", d); end
        reg_wr(2'd3, 32'h80);
        reg_rd(2'd3, d);
        n_cmp++; if (d !== 32'h80) begin n_err++; $display("FAIL lvl_w1c got=%h want=80", d); end
        src_req[7] = 1'b0; step();
        reg_rd(2'd3, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL lvl_fall got=%h want=0", d); end
        reg_wr(2'd0, 32'h1);
        src_req[7] = 1'b1;
        exp_q.push_back({4'd7, 32'h11C});
        wait_irq(8, seen);
        n_cmp++;
        if (!seen) begin
            n_err++; $display("FAIL lvl_timeout got=no_irq want=irq");
        end else if (exp_q.size() == 0) begin
            n_err++; $display("FAIL sb_empty got=present want=none");
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({irq_id, irq_vec} !== e) begin
                n_err++; $display("FAIL lvl_present got=%0d/%h want=%0d/%h", irq_id, irq_vec, e[35:32], e[31:0]);
            end
        end
        src_req[7] = 1'b0;
        step(); step();
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL lvl_drop got=%b want=0", irq); end
    endtask

    task automatic test_service_block();
        bit seen;
        logic [35:0] e;
        src_req[3] = 1'b1;
        exp_q.push_back({4'd3, 32'h10C});
        step();
        src_req[3] = 1'b0;
        wait_irq(8, seen);
        n_cmp++;
        if (!seen) begin
            n_err++; $display("FAIL svc_timeout got=no_irq want=irq");
        end else if (exp_q.size() == 0) begin
            n_err++; $display("FAIL sb_empty got=present want=none");
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({irq_id, irq_vec} !== e) begin
                n_err++; $display("FAIL svc_present got=%0d/%h want=%0d/%h", irq_id, irq_vec, e[35:32], e[31:0]);
            end
        end
        do_eoi();
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL eoi_in_present got=%b want=1", irq); end
        do_ack();
        src_req[0] = 1'b1;
        exp_q.push_back({4'd0, 32'h100});
        step();
        src_req[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL svc_block%0d got=%b want=0", k, irq); end
        end
        do_ack();
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL ack_in_svc got=%b want=0", irq); end
        do_eoi();
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL eoi_gap got=%b want=0", irq); end
        step();
        n_cmp++;
        if (irq !== 1'b1) begin
            n_err++; $display("FAIL post_eoi got=%b want=1", irq);
        end else if (exp_q.size() == 0) begin
            n_err++; $display("FAIL sb_empty got=present want=none");
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({irq_id, irq_vec} !== e) begin
                n_err++; $display("FAIL svc_next got=%0d/%h want=%0d/%h", irq_id, irq_vec, e[35:32], e[31:0]);
            end
        end
        do_ack();
        do_eoi();
    endtask

    task automatic test_vec_wrap();
        bit seen;
        logic [35:0] e;
        reg_wr(2'd2, 32'hFFFF_FFF8);
        src_req[3] = 1'b1;
        exp_q.push_back({4'd3, 32'h0000_0004});
        step();
        src_req[3] = 1'b0;
        wait_irq(8, seen);
        n_cmp++;
        if (!seen) begin
            n_err++; $display("FAIL wrap_timeout got=no_irq want=irq");
        end else if (exp_q.size() == 0) begin
            n_err++; $display("FAIL sb_empty got=present want=none");
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({irq_id, irq_vec} !== e) begin
                n_err++; $display("FAIL wrap got=%0d/%h want=%0d/%h", irq_id, irq_vec, e[35:32], e[31:0]);
            end
        end
        do_ack();
        do_eoi();
    endtask

    task automatic test_reset_mid();
        bit seen;
        logic [35:0] e;
        logic [31:0] d;
        src_req[2] = 1'b1;
        exp_q.push_back({4'd2, 32'h0000_0000});
        step();
        wait_irq(8, seen);
        n_cmp++;
        if (!seen) begin
            n_err++; $display("FAIL rmid_timeout got=no_irq want=irq");
        end else if (exp_q.size() == 0) begin
            n_err++; $display("FAIL sb_empty got=present want=none");
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({irq_id, irq_vec} !== e) begin
                n_err++; $display("FAIL rmid_present got=%0d/%h want=%0d/%h", irq_id, irq_vec, e[35:32], e[31:0]);
            end
        end
        src_req[2] = 1'b0;
        src_req[1] = 1'b1;
        reset = 1'b0;
        #1;
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rmid_irq got=%b want=0", irq); end
        n_cmp++; if (irq_vec !== 32'd0) begin n_err++; $display("FAIL rmid_vec got=%h want=0", irq_vec); end
        for (int a = 0; a < 4; a++) begin
            reg_rd(2'(a), d);
            n_cmp++;
            if (d !== 32'd0) begin n_err++; $display("FAIL rmid_rd%0d got=%h want=0", a, d); end
        end
        step(); step();
        reset = 1'b1;
        exp_q.push_back({4'd1, 32'h204});
        reg_wr(2'd1, 32'hFF);
        reg_wr(2'd2, 32'h200);
        reg_wr(2'd0, 32'h1);
        wait_irq(8, seen);
        n_cmp++;
        if (!seen) begin
            n_err++; $display("FAIL rel_timeout got=no_irq want=irq");
        end else if (exp_q.size() == 0) begin
            n_err++; $display("FAIL sb_empty got=present want=none");
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({irq_id, irq_vec} !== e) begin
                n_err++; $display("FAIL rel_present got=%0d/%h want=%0d/%h", irq_id, irq_vec, e[35:32], e[31:0]);
            end
        end
        do_ack();
        do_eoi();
        src_req[1] = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_leftover got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        reset   = 1'b0;
        src_req = '0;
        wr_en   = 1'b0;
        addr    = '0;
        wr_data = '0;
        ack     = 1'b0;
        eoi     = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_priority();
        test_mask_drop();
        test_w1c_level();
        test_service_block();
        test_vec_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
